// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;

  localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/imem_array.sv
// Word storage for the fetch responder: one synchronous load port, one combinational read port.
module imem_array #(
  parameter int unsigned WSIZE      = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [WSIZE-1:0]      load_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WSIZE-1:0]      rd_data
);

  logic [WSIZE-1:0] mem [2**DEPTH_LOG2];

  // Not reset: contents survive a responder reset.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Read is combinational, so a same-edge load is seen only by later fetches.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: valid/ready request in, fixed-latency valid/ready response out.
// Define IMEM_B2B_EN to accept a new request in the same cycle as the response handshake.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned WSIZE      = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WSIZE-1:0]      req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WSIZE-1:0]      rsp_data,
  output logic                  rsp_fault,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [WSIZE-1:0]      load_data
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("imem_fetch_responder: LATENCY must be within 1..15");
  end

  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state;
  logic [3:0]              cnt;
  logic [WSIZE-1:0]        rd_word;
  logic                    fault_now;
  logic                    accept;

  imem_array #(
    .WSIZE      (WSIZE),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clock     (clock),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (req_addr[DEPTH_LOG2+1:2]),
    .rd_data   (rd_word)
  );

  assign fault_now = (req_addr[1:0] != ALIGN_MASK) || (|req_addr[WSIZE-1:DEPTH_LOG2+2]);

  always_comb begin
    req_ready = 1'b0;
    if (reset) begin
      if (state == IDLE) req_ready = 1'b1;
`ifdef IMEM_B2B_EN
      else if (state == RESP) req_ready = rsp_ready;
`endif
    end
  end

  assign accept = req_valid && req_ready;

  // Accept is checked ahead of the state case so the RESP->accept path (back-to-back) shares it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else if (accept) begin
      rsp_fault <= fault_now;
      rsp_data  <= fault_now ? '0 : rd_word;
      if (LATENCY == 1) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
      end else begin
        state     <= WAIT;
        cnt       <= CNT_INIT;
        rsp_valid <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: ;
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized self-checking bench for imem_fetch_responder against an array-based reference model.
module tb_imem_fetch_responder;

`ifdef IMEM_B2B_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 2;
`endif
  localparam int unsigned WSIZE = 32;
  localparam int unsigned DL    = 8;
  localparam int unsigned DEPTH = 1 << DL;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [WSIZE-1:0]  req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [WSIZE-1:0]  rsp_data;
  logic              rsp_fault;
  logic              load_en = 1'b0;
  logic [DL-1:0]     load_addr = '0;
  logic [WSIZE-1:0]  load_data = '0;

  logic [31:0] model [DEPTH];
  int vectors = 0;
  int miscompares = 0;

  imem_fetch_responder #(
    .WSIZE      (WSIZE),
    .DEPTH_LOG2 (DL),
    .LATENCY    (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (exp_fault(a)) return '0;
    return model[(a / 4) % DEPTH];
  endfunction

  task automatic load_word(input int unsigned idx, input logic [31:0] val);
    @(negedge clock);
    load_en   = 1'b1;
    load_addr = idx[DL-1:0];
    load_data = val;
    model[idx] = val;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // ld_mode: 0 = no load, 1 = load in the accept cycle, 2 = load in the cycle after accept
  task automatic fetch(input logic [31:0] addr, input int hold, input int ld_mode,
                       input int unsigned lidx, input logic [31:0] lval, input string tag);
    logic [31:0] ed;
    bit          ef;
    int          waited;
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = addr;
    if (ld_mode == 1) begin
      load_en = 1'b1; load_addr = lidx[DL-1:0]; load_data = lval;
    end
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept: req_ready=%b required 1", tag, req_ready);
      req_valid = 1'b0; load_en = 1'b0;
      return;
    end
    ed = exp_word(addr);
    ef = exp_fault(addr);
    if (ld_mode == 1) model[lidx] = lval;
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = $urandom;
    load_en   = 1'b0;
    if (ld_mode == 2) begin
      load_en = 1'b1; load_addr = lidx[DL-1:0]; load_data = lval;
      model[lidx] = lval;
    end
    for (int k = 1; k <= int'(LAT); k++) begin
      if (k > 1) begin
        @(negedge clock);
        load_en = 1'b0;
      end
      vectors++;
      if (rsp_valid !== (k == int'(LAT))) begin
        miscompares++;
        $display("FAIL %s latency cycle %0d: rsp_valid=%b required %b", tag, k, rsp_valid, k == int'(LAT));
      end
    end
    vectors++;
    if ({rsp_fault, rsp_data} !== {ef, ed}) begin
      miscompares++;
      $display("FAIL %s response: fault=%b data=%h required fault=%b data=%h", tag, rsp_fault, rsp_data, ef, ed);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      load_en = 1'b0;
      vectors++;
      if ({rsp_valid, req_ready, rsp_fault, rsp_data} !== {1'b1, 1'b0, ef, ed}) begin
        miscompares++;
        $display("FAIL %s hold %0d: valid=%b ready=%b fault=%b data=%h required 1 0 %b %h",
                 tag, h, rsp_valid, req_ready, rsp_fault, rsp_data, ef, ed);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    load_en   = 1'b0;
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s release: valid=%b ready=%b required 0 1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({rsp_valid, rsp_fault, req_ready, rsp_data} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b fault=%b ready=%b data=%h required 0 0 0 0",
               rsp_valid, rsp_fault, req_ready, rsp_data);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
    for (int unsigned i = 0; i < DEPTH; i++) load_word(i, $urandom);
  endtask

  task automatic test_basic();
    load_word(3, 32'h2008_0005);
    fetch(32'h0000_000C, 0, 0, 0, '0, "basic_idx3");
    fetch(32'h0000_0000, 0, 0, 0, '0, "basic_idx0");
    fetch(32'h0000_03FC, 0, 0, 0, '0, "basic_top");
  endtask

  task automatic test_fault();
    fetch(32'h0000_000E, 0, 0, 0, '0, "fault_misaligned");
    fetch(32'h0000_0400, 0, 0, 0, '0, "fault_range");
    fetch(32'h8000_0001, 0, 0, 0, '0, "fault_both");
  endtask

  task automatic test_backpressure();
    fetch(32'h0000_000C, 5, 0, 0, '0, "backpressure");
  endtask

  task automatic test_read_before_write();
    load_word(4, 32'hAAAA_0000);
    fetch(32'h0000_0010, 0, 1, 4, 32'hBBBB_0000, "rbw_old");
    fetch(32'h0000_0010, 0, 0, 0, '0, "rbw_new");
    fetch(32'h0000_0014, 1, 2, 5, 32'hCCCC_0000, "load_after_accept");
    fetch(32'h0000_0014, 0, 0, 0, '0, "load_after_new");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0008;
    @(negedge clock);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    vectors++;
    if ({rsp_valid, rsp_fault, req_ready, rsp_data} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b fault=%b ready=%b data=%h required 0 0 0 0",
               rsp_valid, rsp_fault, req_ready, rsp_data);
    end
    reset = 1'b1;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      @(negedge clock);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale cycle %0d: rsp_valid=%b required 0", i, rsp_valid);
      end
    end
    fetch(32'h0000_000C, 0, 0, 0, '0, "reset_array_kept");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0]  a;
      int unsigned  idx;
      int           mode;
      idx = $urandom_range(DEPTH - 1);
      a   = ($urandom_range(3) != 0) ? 32'(idx * 4) : 32'($urandom);
      mode = $urandom_range(2);
      fetch(a, $urandom_range(3), mode,
            ($urandom_range(1) != 0) ? ((a / 4) % DEPTH) : idx, $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
`ifdef IMEM_B2B_EN
    @(negedge clock);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    req_addr  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if ({rsp_valid, rsp_fault, rsp_data} !== {2'b10, model[i]}) begin
        miscompares++;
        $display("FAIL b2b resp %0d: valid=%b fault=%b data=%h required 1 0 %h",
                 i, rsp_valid, rsp_fault, rsp_data, model[i]);
      end
      if (i < 2) req_addr = 32'(4 * (i + 1));
      else req_valid = 1'b0;
    end
    @(negedge clock);
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b drain: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_backpressure();
    test_read_before_write();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface driven by the program counter.
- Accepts a byte address on a valid/ready request channel and looks up the word in an internal array.
- Returns the instruction after a fixed, parameterised latency on a valid/ready response channel.
- A loader write port fills the array before or during execution.

Parameters:
- WSIZE, 32, data and address width in bits.
- DEPTH_LOG2, 8, log2 of array depth in words (256 words).
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  WSIZE  byte address from the PC.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WSIZE  instruction word; 0 when faulted.
- rsp_fault  out  1  misaligned or out-of-range address.
- load_en  in  1  loader write strobe.
- load_addr  in  DEPTH_LOG2  word index to write.
- load_data  in  WSIZE  word to write.

Behaviour:
- Reset (reset=0 at a rising edge): state goes to IDLE, rsp_valid=0, rsp_data=0, rsp_fault=0, counter=0, and any in-flight request is dropped. req_ready=0 while reset=0. The array is NOT cleared.
- States:
  - IDLE: req_ready=1. When req_valid=1, the request is accepted. At accept, capture word = array[req_addr[DEPTH_LOG2+1:2]] and the fault flag. If LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-2.
  - WAIT: req_ready=0. Decrement counter each cycle; at counter==0, go to RESP.
  - RESP: rsp_valid=1, rsp_data and rsp_fault stable, req_ready=0. When rsp_ready=1, go to IDLE and drop rsp_valid the next cycle.
- Timing: accept at edge N gives rsp_valid=1 from edge N+LATENCY. Base throughput is one fetch per LATENCY+1 cycles.
- Fault: set if req_addr[1:0]!=0 or req_addr[WSIZE-1:DEPTH_LOG2+2]!=0. When faulted, rsp_data=0. Fault is evaluated at accept.
- Loader:
  - Writes the array on any cycle, independent of state.
  - A load to the same index in the same cycle as an accept returns the OLD word (read-before-write).
  - A load after accept does not alter the captured response.
- rsp_valid never deasserts without rsp_ready, except on reset.
- req_addr is ignored outside the accept cycle.
- Out-of-range LATENCY: elaboration error.

Optional Feature:
- Macro: IMEM_B2B_EN.
- Defined: in RESP, req_ready = rsp_ready (combinational). A request presented in the same cycle as the response handshake is accepted, and the FSM goes directly to WAIT or RESP instead of IDLE. Throughput becomes one fetch per LATENCY cycles; with LATENCY=1, one per cycle.
- Undefined: req_ready=0 in RESP, as in the base behaviour.

Decomposition:
- imem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - LATENCY legality bounds;
  - alignment mask constant (2'b00).
- One natural sub-module, imem_array: the 2^DEPTH_LOG2 x WSIZE storage with one write port (load) and one combinational read port. The FSM, counter and response registers stay in imem_fetch_responder.

Test Plan:
- Load word 0x20080005 at index 3. With LATENCY=2, request addr 0x0000000C → rsp_valid rises exactly 2 cycles after accept, rsp_data=0x20080005, rsp_fault=0.
- Request addr 0x0000000E → rsp_fault=1, rsp_data=0. Request addr 0x00000400 with DEPTH_LOG2=8 → rsp_fault=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid → data stable and req_ready=0 throughout; raise rsp_ready → rsp_valid=0 next cycle and req_ready=1.
- Accept addr 0x10 at index 4 (old 0xAAAA0000) while load_en writes 0xBBBB0000 to index 4 in the same cycle → response is 0xAAAA0000. A next fetch of 0x10 returns 0xBBBB0000.
- Drive reset=0 during WAIT → rsp_valid=0, rsp_fault=0, req_ready=0. After release, the array still holds prior loads and no stale response appears.
- With IMEM_B2B_EN, LATENCY=1, req_valid and rsp_ready held high over addrs 0x0, 0x4, 0x8 → three responses on consecutive cycles, in order.
